nn_reg_file: RTL and testbench
==============================

// Module: nn_reg_file
// PURPOSE
//  Memory-mapped register bank for the 2-2-1 neural-network accelerator.
//  - Bus side (Wishbone-style slave): writes operands, weights and biases.
//  - Datapath side: exports them as flat 32-bit buses.
//  - Captures the datapath result (NN_result) when ready pulses.
//  - Result is readable on the bus and driven on final_res.
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  base of the 256-byte register window
//  DW         32             data/register width
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst_l      in   1   synchronous, active-high reset (1 = reset; legacy name kept)
//  NN_result  in   32  result word from NN datapath
//  ready      in   1   datapath result valid; loads result register
//  wbs_adr_i  in   32  byte address
//  wren       in   1   bus write enable (one write per cycle high)
//  wbs_dat_i  in   32  bus write data
//  wbs_ack_o  out  1   write acknowledge
//  wbs_dat_o  out  32  read data (combinational on wbs_adr_i)
//  opA, opB   out  32  input operands x1, x2
//  w11,w12,w21,w22  out 32  hidden-layer weights
//  b1, b2     out  32  hidden-layer biases
//  w31, w32   out  32  output-layer weights
//  b3         out  32  output-layer bias
//  final_res  out  32  captured result register
// BEHAVIOUR
//  - Address map (offset from BASE_ADDR):
//    - RW: 0x00 opA, 0x04 opB, 0x08 w11, 0x0C w12, 0x10 w21, 0x14 w22,
//      0x18 b1, 0x1C b2, 0x20 w31, 0x24 w32, 0x28 b3
//    - 0x2C reserved: reads 0, writes ignored
//    - 0x30 result: RO
//  - Decode: hit when wbs_adr_i[31:8]==BASE_ADDR[31:8].
//    - Offset = wbs_adr_i[7:2]; wbs_adr_i[1:0] ignored.
//    - Offsets >0x30, or a miss, read 0; writes there are ignored.
//  - Reset: every register, final_res, and wbs_ack_o = 0.
//  - Write: wren=1 at rising edge with a hit on an RW offset loads wbs_dat_i.
//    - The output port shows the new value the cycle after the edge (1-cycle latency).
//    - Writes to 0x30 are ignored.
//  - Result: ready=1 at rising edge loads NN_result into the result register.
//    - final_res = result register.
//    - The register holds its value while ready=0.
//    - ready level-sensitive: every cycle high reloads.
//  - wbs_ack_o: registered; equals wren from the previous cycle (any address).
//    - One-cycle pulse per write cycle.
//  - wbs_dat_o: pure combinational mux of the addressed register, no wait states.
//    - A read of an address written this edge shows the new value next cycle.
//  - Simultaneous ready and wren to 0x30: ready wins (bus write ignored anyway).
//  - Reset dominates wren and ready in the same cycle.
// STRUCTURE
//  - Package nn_reg_pkg:
//    - localparam offsets OFF_OPA..OFF_RESULT (byte offsets above)
//    - BASE_ADDR default
//    - typedef logic [31:0] word_t
//  - One natural sub-module: nn_reg32, a 32-bit register with sync active-high
//    reset and load enable; instantiated 12x (11 RW + result).
//  - Top holds address decode, write-enable fan-out, read mux and ack flop.
// TESTING
//  - Reset: rst_l=1 for 2 cycles -> all outputs 0, wbs_ack_o=0.
//  - Write opA: adr 0x3000_0000, dat 0x1234_5678, wren 1 cycle
//    -> opA=0x1234_5678 next cycle, wbs_ack_o pulses 1 cycle.
//  - Write opB: 0x8765_4321 @0x3000_0004 -> opB updated, opA unchanged;
//    read both back via wbs_dat_o.
//  - Result: NN_result=0xDEAD_BEEF, ready 1 cycle then 0 -> final_res=0xDEAD_BEEF.
//    - adr 0x3000_0030 -> wbs_dat_o=0xDEAD_BEEF.
//    - Changing NN_result afterwards leaves final_res unchanged.
//  - Walk all 11 RW offsets with distinct patterns (e.g. 0xA5A5_0000+offset)
//    -> each port and read-back correct, no aliasing.
//  - Boundary cases:
//    - Write 0x1111_1111 to 0x3000_0030 -> result unchanged.
//    - Write to 0x3000_0100 or 0x2000_0000 -> no register changes, reads 0.
//    - Reset asserted mid-sequence -> all registers clear.

Source files
------------

// File: rtl/nn_reg_pkg.sv
// Shared definitions for the 2-2-1 neural-network accelerator register bank.
//
// Contents:
//   word_t             32-bit register word
//   BASE_ADDR_DEFAULT  default base of the 256-byte register window
//   OFF_*              byte offsets of every register in the window
//   NUM_RW             number of bus-writable registers (opA .. b3)
//   reg_index()        byte offset -> word index (drops byte-lane bits)
package nn_reg_pkg;

  typedef logic [31:0] word_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3000_0000;

  localparam logic [7:0] OFF_OPA      = 8'h00;
  localparam logic [7:0] OFF_OPB      = 8'h04;
  localparam logic [7:0] OFF_W11      = 8'h08;
  localparam logic [7:0] OFF_W12      = 8'h0C;
  localparam logic [7:0] OFF_W21      = 8'h10;
  localparam logic [7:0] OFF_W22      = 8'h14;
  localparam logic [7:0] OFF_B1       = 8'h18;
  localparam logic [7:0] OFF_B2       = 8'h1C;
  localparam logic [7:0] OFF_W31      = 8'h20;
  localparam logic [7:0] OFF_W32      = 8'h24;
  localparam logic [7:0] OFF_B3       = 8'h28;
  localparam logic [7:0] OFF_RESERVED = 8'h2C;
  localparam logic [7:0] OFF_RESULT   = 8'h30;

  localparam int NUM_RW = 11;

  // Word index of the result register within the window.
  localparam logic [5:0] IDX_RESULT = OFF_RESULT[7:2];

  function automatic logic [5:0] reg_index(input logic [7:0] byte_off);
    return byte_off[7:2];
  endfunction

endpackage

// File: rtl/nn_reg32.sv
// Generic register with synchronous active-high reset and load enable.
//
// Ports:
//   clk   in   1   clock, rising edge
//   rst   in   1   synchronous reset, active high, clears q
//   load  in   1   when high (and not in reset) q takes d
//   d     in   W   next value
//   q     out  W   stored value
module nn_reg32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/nn_reg_file.sv
// Memory-mapped register bank for the 2-2-1 neural-network accelerator.
// The bus side writes operands, weights and biases; the datapath side sees
// them as flat buses. The datapath result is captured whenever ready is high
// and is readable on the bus and on final_res.
//
// Ports:
//   clk        in   1    clock, all state changes on the rising edge
//   rst_l      in   1    synchronous reset, active HIGH (historical name)
//   NN_result  in   DW   result word from the datapath
//   ready      in   1    loads NN_result into the result register each cycle high
//   wbs_adr_i  in   32   byte address; [31:8] selects window, [7:2] register
//   wren       in   1    bus write enable, one write per cycle high
//   wbs_dat_i  in   DW   bus write data
//   wbs_ack_o  out  1    registered copy of wren
//   wbs_dat_o  out  DW   combinational read data for wbs_adr_i
//   opA..b3    out  DW   register contents for the datapath
//   final_res  out  DW   captured result register
module nn_reg_file
  import nn_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          DW        = 32
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic [DW-1:0] NN_result,
  input  logic          ready,
  input  logic [31:0]   wbs_adr_i,
  input  logic          wren,
  input  logic [DW-1:0] wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic [DW-1:0] opA,
  output logic [DW-1:0] opB,
  output logic [DW-1:0] w11,
  output logic [DW-1:0] w12,
  output logic [DW-1:0] w21,
  output logic [DW-1:0] w22,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] w31,
  output logic [DW-1:0] w32,
  output logic [DW-1:0] b3,
  output logic [DW-1:0] final_res
);

  logic              hit;
  logic [5:0]        idx;
  logic [NUM_RW-1:0] wr_en;
  logic [DW-1:0]     rw_q [NUM_RW];
  logic [DW-1:0]     res_q;
  logic              ack_q;

  // Byte-lane bits carry no meaning: all accesses are whole words.
  logic unused_adr_bits;
  assign unused_adr_bits = ^wbs_adr_i[1:0];

  assign hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign idx = reg_index(wbs_adr_i[7:0]);

  // Only the eleven RW slots get a write strobe; reserved, result and
  // out-of-range offsets fall through with no enable set.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      wr_en[i] = wren && hit && (idx == 6'(i));
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw
    nn_reg32 #(.W(DW)) u_reg (
      .clk  (clk),
      .rst  (rst_l),
      .load (wr_en[g]),
      .d    (wbs_dat_i),
      .q    (rw_q[g])
    );
  end

  nn_reg32 #(.W(DW)) u_result (
    .clk  (clk),
    .rst  (rst_l),
    .load (ready),
    .d    (NN_result),
    .q    (res_q)
  );

  always_ff @(posedge clk) begin
    if (rst_l) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= wren;
    end
  end

  always_comb begin
    wbs_dat_o = '0;
    if (hit) begin
      if (idx < 6'(NUM_RW)) begin
        wbs_dat_o = rw_q[idx[3:0]];
      end else if (idx == IDX_RESULT) begin
        wbs_dat_o = res_q;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign final_res = res_q;

  assign opA = rw_q[OFF_OPA[5:2]];
  assign opB = rw_q[OFF_OPB[5:2]];
  assign w11 = rw_q[OFF_W11[5:2]];
  assign w12 = rw_q[OFF_W12[5:2]];
  assign w21 = rw_q[OFF_W21[5:2]];
  assign w22 = rw_q[OFF_W22[5:2]];
  assign b1  = rw_q[OFF_B1[5:2]];
  assign b2  = rw_q[OFF_B2[5:2]];
  assign w31 = rw_q[OFF_W31[5:2]];
  assign w32 = rw_q[OFF_W32[5:2]];
  assign b3  = rw_q[OFF_B3[5:2]];

endmodule

// File: tb/tb_nn_reg_file.sv
module tb_nn_reg_file;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic [31:0] NN_result = '0;
  logic        ready = 1'b0;
  logic [31:0] wbs_adr_i = '0;
  logic        wren = 1'b0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] opA, opB, w11, w12, w21, w22, b1, b2, w31, w32, b3, final_res;

  int checks = 0;
  int errors = 0;

  // Reference model: eleven RW words indexed by byte offset / 4, plus result.
  logic [31:0] m_rw [11];
  logic [31:0] m_res;
  logic        m_ack;

  logic [31:0] port_vec [11];
  assign port_vec[0]  = opA;
  assign port_vec[1]  = opB;
  assign port_vec[2]  = w11;
  assign port_vec[3]  = w12;
  assign port_vec[4]  = w21;
  assign port_vec[5]  = w22;
  assign port_vec[6]  = b1;
  assign port_vec[7]  = b2;
  assign port_vec[8]  = w31;
  assign port_vec[9]  = w32;
  assign port_vec[10] = b3;

  always #5 clk = ~clk;

  nn_reg_file dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .NN_result (NN_result),
    .ready     (ready),
    .wbs_adr_i (wbs_adr_i),
    .wren      (wren),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .opA       (opA),
    .opB       (opB),
    .w11       (w11),
    .w12       (w12),
    .w21       (w21),
    .w22       (w22),
    .b1        (b1),
    .b2        (b2),
    .w31       (w31),
    .w32       (w32),
    .b3        (b3),
    .final_res (final_res)
  );

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int off;
    if (a[31:8] != 24'h30_0000) return 32'h0;
    off = int'(a[7:0]) / 4 * 4;
    if (off < 'h2C) return m_rw[off / 4];
    if (off == 'h30) return m_res;
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 11; i++) chk($sformatf("port%0d", i), port_vec[i], m_rw[i]);
    chk("final_res", final_res, m_res);
    chk("ack", {31'b0, wbs_ack_o}, {31'b0, m_ack});
    chk("rdata_cur", wbs_dat_o, exp_read(wbs_adr_i));
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 ns later.
  task automatic step(input logic r, input logic w, input logic rdy,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] n);
    @(negedge clk);
    rst_l = r; wren = w; ready = rdy; wbs_adr_i = a; wbs_dat_i = d; NN_result = n;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 11; i++) m_rw[i] = 32'h0;
      m_res = 32'h0;
      m_ack = 1'b0;
    end else begin
      m_ack = w;
      if (rdy) m_res = n;
      if (w && a[31:8] == 24'h30_0000 && a[7:0] < 8'h2C) m_rw[int'(a[7:0]) / 4] = d;
    end
    #1;
    check_all();
  endtask

  // Combinational read between edges; strobes are dropped so nothing is written.
  task automatic check_read(input string tag, input logic [31:0] a);
    rst_l = 1'b0; wren = 1'b0; ready = 1'b0; wbs_adr_i = a;
    #1;
    chk(tag, wbs_dat_o, exp_read(a));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, NN_result);
  endtask

  initial begin
    for (int i = 0; i < 11; i++) m_rw[i] = 32'h0;
    m_res = 32'h0;
    m_ack = 1'b0;

    // Reset dominates wren and ready.
    step(1'b1, 1'b1, 1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_read("rd_result_rst", 32'h3000_0030);

    // opA write, ack pulse
    step(1'b0, 1'b1, 1'b0, 32'h3000_0000, 32'h1234_5678, 32'h0);
    chk("opA_direct", opA, 32'h1234_5678);
    chk("ack_pulse", {31'b0, wbs_ack_o}, 32'h1);
    idle();
    chk("ack_drop", {31'b0, wbs_ack_o}, 32'h0);

    // opB write, read both
    step(1'b0, 1'b1, 1'b0, 32'h3000_0004, 32'h8765_4321, 32'h0);
    chk("opB_direct", opB, 32'h8765_4321);
    chk("opA_kept", opA, 32'h1234_5678);
    check_read("rd_opA", 32'h3000_0000);
    check_read("rd_opB", 32'h3000_0004);

    // Result capture and hold
    step(1'b0, 1'b0, 1'b1, 32'h3000_0030, 32'h0, 32'hDEAD_BEEF);
    chk("res_direct", final_res, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b0, 32'h3000_0030, 32'h0, 32'h0BAD_F00D);
    chk("res_hold", final_res, 32'hDEAD_BEEF);
    check_read("rd_result", 32'h3000_0030);

    // Walk all RW offsets
    for (int o = 0; o < 'h2C; o += 4)
      step(1'b0, 1'b1, 1'b0, 32'h3000_0000 + 32'(o), 32'hA5A5_0000 + 32'(o), 32'h0);
    for (int o = 0; o < 'h2C; o += 4) begin
      chk($sformatf("walk_port%0d", o / 4), port_vec[o / 4], 32'hA5A5_0000 + 32'(o));
      check_read($sformatf("walk_rd%0d", o / 4), 32'h3000_0000 + 32'(o));
    end
    check_read("rd_reserved", 32'h3000_002C);
    check_read("rd_beyond", 32'h3000_0034);

    // Boundary: writes to result, reserved, and misses are ignored
    step(1'b0, 1'b1, 1'b0, 32'h3000_0030, 32'h1111_1111, 32'h0);
    chk("res_ro", final_res, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, 32'h3000_002C, 32'h2222_2222, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h3000_0100, 32'h3333_3333, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h2000_0000, 32'h4444_4444, 32'h0);
    chk("miss_opA", opA, 32'hA5A5_0000);
    check_read("rd_miss_hi", 32'h3000_0100);
    check_read("rd_miss_lo", 32'h2000_0000);
    // ready and a bus write to the result slot together: ready wins
    step(1'b0, 1'b1, 1'b1, 32'h3000_0030, 32'h5555_5555, 32'hCAFE_0001);
    chk("ready_wins", final_res, 32'hCAFE_0001);
    // byte-lane bits ignored
    step(1'b0, 1'b1, 1'b0, 32'h3000_0007, 32'h6666_6666, 32'h0);
    chk("lane_ign", opB, 32'h6666_6666);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) < 8) ? 32'h3000_0000 : $urandom;
      a[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 'h33));
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           a, $urandom, $urandom);
      check_read("rand_rd", {24'h30_0000, 8'($urandom_range(0, 'h3F))});
    end

    // Reset mid-sequence clears everything
    step(1'b0, 1'b1, 1'b1, 32'h3000_0028, 32'h7777_7777, 32'h8888_8888);
    step(1'b1, 1'b1, 1'b1, 32'h3000_0000, 32'h9999_9999, 32'h9999_9999);
    chk("rst_mid_opA", opA, 32'h0);
    chk("rst_mid_b3", b3, 32'h0);
    chk("rst_mid_res", final_res, 32'h0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
